// File: rtl/alu_issuer_pkg.sv
// ---------------------------------------------------------------------------
// alu_issuer_pkg
// Shared definitions for the ALU command issuer:
//   - opcode encodings used on cmd_inst / rsp_inst
//   - issuer FSM state type
//   - width of one buffered command entry {inst, x, y, sel}
// ---------------------------------------------------------------------------
package alu_issuer_pkg;

    localparam int OPC_W = 2;

    localparam logic [OPC_W-1:0] OP_ADD  = 2'b00;
    localparam logic [OPC_W-1:0] OP_MUL  = 2'b01;
    localparam logic [OPC_W-1:0] OP_COMP = 2'b10;
    localparam logic [OPC_W-1:0] OP_MUX  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } issuer_state_e;

    // One command entry: opcode + two operands + mux select.
    function automatic int cmd_entry_width(input int dwidth);
        return OPC_W + 2 * dwidth + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO. Push is ignored when full, pop is ignored when
// empty; a simultaneous push and pop leaves the occupancy unchanged. The head
// entry is presented combinationally on rdata_o.
// Parameters:
//   ENTRY_W    - entry width in bits
//   FIFO_DEPTH - number of entries (power of two, >= 2)
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (empties the FIFO)
//   push_i     - write wdata_i at the tail
//   wdata_i    - entry to write
//   pop_i      - drop the head entry
//   rdata_o    - head entry
//   full_o     - occupancy == FIFO_DEPTH
//   empty_o    - occupancy == 0
//   count_o    - current occupancy
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int ENTRY_W    = 11,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q;
    logic [AW:0]        rd_ptr_q;
    logic [CW-1:0]      count_s;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_s == FULL_CNT);
    assign empty_o   = (count_s == {CW{1'b0}});
    assign count_o   = count_s;
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Command front-end for the two-operand operation unit (ADD, MUL, COMP, MUX).
// Commands are accepted over cmd_valid/cmd_ready into a FIFO, executed one at
// a time and returned in order as a registered, opcode-tagged response over
// rsp_valid/rsp_ready.
// Build option:
//   ALU_ISSUER_SIGNED_COMP_EN - when defined COMP compares x and y as
//                               two's-complement; otherwise unsigned.
// Parameters:
//   DWIDTH     - operand width (>= 2)
//   FIFO_DEPTH - command FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    - command handshake (cmd_ready = not full)
//   cmd_inst, cmd_x, cmd_y,
//   cmd_sel                  - opcode, operands, mux select
//   rsp_valid / rsp_ready    - response handshake
//   rsp_inst, rsp_data,
//   rsp_flag                 - opcode tag, 2*DWIDTH result, flag bit
//   busy                     - FIFO non-empty or an operation in flight
// ---------------------------------------------------------------------------
module alu_cmd_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DWIDTH     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_inst,
    input  logic [DWIDTH-1:0]   cmd_x,
    input  logic [DWIDTH-1:0]   cmd_y,
    input  logic                cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_inst,
    output logic [2*DWIDTH-1:0] rsp_data,
    output logic                rsp_flag,
    output logic                busy
);

    localparam int ENTRY_W = cmd_entry_width(DWIDTH);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    // FIFO interface
    logic [ENTRY_W-1:0] fifo_wdata_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic               fifo_push_s;
    logic               fifo_pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;

    // Head entry fields
    logic [1:0]         head_inst_s;
    logic [DWIDTH-1:0]  head_x_s;
    logic [DWIDTH-1:0]  head_y_s;
    logic               head_sel_s;

    // FSM, operand and response registers
    issuer_state_e       state_q;
    logic [1:0]          op_inst_q;
    logic [DWIDTH-1:0]   op_x_q;
    logic [DWIDTH-1:0]   op_y_q;
    logic                op_sel_q;
    logic                rsp_valid_q;
    logic [1:0]          rsp_inst_q;
    logic [2*DWIDTH-1:0] rsp_data_q;
    logic                rsp_flag_q;

    // Datapath
    logic [DWIDTH:0]     sum_s;
    logic [2*DWIDTH-1:0] prod_s;
    logic [2*DWIDTH-1:0] rsp_data_d;
    logic                rsp_flag_d;

    // Held low during reset so no command is seen as accepted then.
    assign cmd_ready    = rst_n & ~fifo_full_s;
    assign fifo_push_s  = cmd_valid & cmd_ready;
    assign fifo_wdata_s = {cmd_inst, cmd_x, cmd_y, cmd_sel};

    alu_cmd_fifo #(
        .ENTRY_W    (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign head_inst_s = fifo_rdata_s[ENTRY_W-1 -: 2];
    assign head_x_s    = fifo_rdata_s[DWIDTH+1 +: DWIDTH];
    assign head_y_s    = fifo_rdata_s[1 +: DWIDTH];
    assign head_sel_s  = fifo_rdata_s[0];

    // Pop from IDLE whenever work is queued, or from RESP on the accepting
    // edge so back-to-back results need only two cycles each.
    always_comb begin
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: fifo_pop_s = ~fifo_empty_s;
            ST_RESP: fifo_pop_s = rsp_ready & ~fifo_empty_s;
            default: fifo_pop_s = 1'b0;
        endcase
    end

    assign sum_s  = {1'b0, op_x_q} + {1'b0, op_y_q};
    assign prod_s = {{DWIDTH{1'b0}}, op_x_q} * {{DWIDTH{1'b0}}, op_y_q};

    // Result evaluation from the operand registers; unused upper bits stay 0.
    always_comb begin
        rsp_data_d = {(2*DWIDTH){1'b0}};
        rsp_flag_d = 1'b0;
        case (op_inst_q)
            OP_ADD: begin
                rsp_data_d = {{DWIDTH{1'b0}}, sum_s[DWIDTH-1:0]};
                rsp_flag_d = sum_s[DWIDTH];
            end
            OP_MUL: begin
                rsp_data_d = prod_s;
                rsp_flag_d = 1'b0;
            end
            OP_COMP: begin
                rsp_data_d = {(2*DWIDTH){1'b0}};
`ifdef ALU_ISSUER_SIGNED_COMP_EN
                rsp_flag_d = ($signed(op_x_q) >= $signed(op_y_q));
`else
                rsp_flag_d = (op_x_q >= op_y_q);
`endif
            end
            OP_MUX: begin
                rsp_data_d = {{DWIDTH{1'b0}}, (op_sel_q ? op_x_q : op_y_q)};
                rsp_flag_d = op_sel_q;
            end
            default: begin
                rsp_data_d = {(2*DWIDTH){1'b0}};
                rsp_flag_d = 1'b0;
            end
        endcase
    end

    // Issuer FSM with operand capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_inst_q   <= 2'b00;
            op_x_q      <= {DWIDTH{1'b0}};
            op_y_q      <= {DWIDTH{1'b0}};
            op_sel_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= 2'b00;
            rsp_data_q  <= {(2*DWIDTH){1'b0}};
            rsp_flag_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop_s) begin
                        op_inst_q <= head_inst_s;
                        op_x_q    <= head_x_s;
                        op_y_q    <= head_y_s;
                        op_sel_q  <= head_sel_s;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_inst_q  <= op_inst_q;
                    rsp_data_q  <= rsp_data_d;
                    rsp_flag_q  <= rsp_flag_d;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // rsp_* stay frozen until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (fifo_pop_s) begin
                            op_inst_q <= head_inst_s;
                            op_x_q    <= head_x_s;
                            op_y_q    <= head_y_s;
                            op_sel_q  <= head_sel_s;
                            state_q   <= ST_EXEC;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flag  = rsp_flag_q;
    assign busy      = (fifo_count_s != {CW{1'b0}}) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Self-checking bench for alu_cmd_issuer. Directed cases cover latency,
// packing, COMP signedness, back-pressure with a full FIFO and mid-operation
// reset; a randomized phase runs against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_inst;
    logic [DW-1:0]   cmd_x;
    logic [DW-1:0]   cmd_y;
    logic            cmd_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_inst;
    logic [2*DW-1:0] rsp_data;
    logic            rsp_flag;
    logic            busy;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_inst  (cmd_inst),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .busy      (busy)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] inst;
        longint     data;
        bit         flag;
    } rsp_t;

    rsp_t exp_q[$];

    // Reference: results straight from the operation definitions.
    function automatic rsp_t ref_model(input logic [1:0] inst, input int x, input int y, input bit sel);
        rsp_t r;
        int   lim;
        int   sx;
        int   sy;
        lim    = 1 << DW;
        r.inst = inst;
        r.data = 0;
        r.flag = 1'b0;
        case (inst)
            2'd0: begin
                r.data = (x + y) % lim;
                r.flag = ((x + y) >= lim);
            end
            2'd1: r.data = x * y;
            2'd2: begin
                sx = (x >= lim / 2) ? x - lim : x;
                sy = (y >= lim / 2) ? y - lim : y;
`ifdef ALU_ISSUER_SIGNED_COMP_EN
                r.flag = (sx >= sy);
`else
                r.flag = (x >= y);
`endif
            end
            default: begin
                r.data = sel ? x : y;
                r.flag = sel;
            end
        endcase
        return r;
    endfunction

    // Monitor: records accepted commands, scores responses in order,
    // checks that a stalled response stays stable, and measures spacing.
    bit              gap_en = 1'b0;
    int              gap_hs = 0;
    time             last_hs = 0;
    bit              held = 1'b0;
    logic [1:0]      h_inst;
    logic [2*DW-1:0] h_data;
    logic            h_flag;

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                held = 1'b0;
            end else begin
                if (held && rsp_valid) begin
                    check_val("hold_inst", rsp_inst, h_inst);
                    check_val("hold_data", rsp_data, h_data);
                    check_val("hold_flag", rsp_flag, h_flag);
                end
                if (cmd_valid && cmd_ready)
                    exp_q.push_back(ref_model(cmd_inst, cmd_x, cmd_y, cmd_sel));
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("rsp_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("rsp_inst", rsp_inst, e.inst);
                        check_val("rsp_data", rsp_data, e.data);
                        check_val("rsp_flag", rsp_flag, e.flag);
                    end
                    if (gap_en) begin
                        if (gap_hs > 0) check_val("rsp_gap", $time - last_hs, 20);
                        gap_hs++;
                        last_hs = $time;
                    end
                end
                held   = rsp_valid && !rsp_ready;
                h_inst = rsp_inst;
                h_data = rsp_data;
                h_flag = rsp_flag;
            end
        end
    end

    // Drive one command; returns 1 time unit after its accepting edge.
    task automatic send(input logic [1:0] inst, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic sel);
        int w;
        cmd_inst  = inst;
        cmd_x     = x;
        cmd_y     = y;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) check_val("send_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(2'($urandom_range(0, 3)), DW'($urandom_range(0, 15)),
             DW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    // Wait (bounded) for a response and compare it to fixed values.
    task automatic expect_rsp(input string tag, input logic [1:0] inst, input logic [7:0] data, input logic flag);
        int w;
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check_val({tag, "_valid"}, rsp_valid, 1);
        check_val({tag, "_inst"}, rsp_inst, inst);
        check_val({tag, "_data"}, rsp_data, data);
        check_val({tag, "_flag"}, rsp_flag, flag);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((busy || rsp_valid) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("idle_busy", busy, 0);
    endtask

    bit rand_en = 1'b0;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_inst  = 2'b00;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_sel   = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_inst", rsp_inst, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_flag", rsp_flag, 0);
        check_val("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check_val("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // Latency: accepted at k, valid after k+2
        rsp_ready = 1'b1;
        send(2'b00, 4'hF, 4'h1, 1'b0);
        @(posedge clk); #1;
        check_val("lat_k1_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check_val("lat_k2_valid", rsp_valid, 1);
        check_val("add_data", rsp_data, 8'h00);
        check_val("add_flag", rsp_flag, 1);
        check_val("add_inst", rsp_inst, 2'b00);
        @(posedge clk); #1;

        // MUL, MUX, COMP
        send(2'b01, 4'hF, 4'hF, 1'b0);
        expect_rsp("mul", 2'b01, 8'hE1, 1'b0);
        send(2'b11, 4'hA, 4'h5, 1'b1);
        expect_rsp("mux", 2'b11, 8'h0A, 1'b1);
        send(2'b10, 4'h3, 4'h9, 1'b0);
        expect_rsp("comp_lt", 2'b10, 8'h00, 1'b0);
        send(2'b10, 4'h9, 4'h9, 1'b0);
        expect_rsp("comp_eq", 2'b10, 8'h00, 1'b1);
        send(2'b10, 4'hF, 4'h1, 1'b0);
`ifdef ALU_ISSUER_SIGNED_COMP_EN
        expect_rsp("comp_sgn", 2'b10, 8'h00, 1'b0);
`else
        expect_rsp("comp_sgn", 2'b10, 8'h00, 1'b1);
`endif
        wait_idle();

        // Back-pressure: one in RESP + four queued, sixth must stall
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_rand();
        cmd_inst  = 2'($urandom_range(0, 3));
        cmd_x     = DW'($urandom_range(0, 15));
        cmd_y     = DW'($urandom_range(0, 15));
        cmd_sel   = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("full_cmd_ready", cmd_ready, 0);
            check_val("full_rsp_valid", rsp_valid, 1);
            check_val("full_busy", busy, 1);
            @(posedge clk); #1;
        end
        gap_en    = 1'b1;
        gap_hs    = 0;
        rsp_ready = 1'b1;
        begin
            int w;
            w = 0;
            while (!cmd_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check_val("full_reopen", cmd_ready, 1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle();
        check_val("bp_drain", exp_q.size(), 0);
        check_val("bp_results", gap_hs, 6);
        gap_en = 1'b0;

        // Reset while in RESP with a full FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_rand();
        check_val("pre_rst_ready", cmd_ready, 0);
        check_val("pre_rst_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", rsp_valid, 0);
        check_val("mid_rst_inst", rsp_inst, 0);
        check_val("mid_rst_data", rsp_data, 0);
        check_val("mid_rst_flag", rsp_flag, 0);
        check_val("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_val("post_rst_ready", cmd_ready, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val("post_rst_valid", rsp_valid, 0);
            check_val("post_rst_busy", busy, 0);
        end

        // Randomized traffic with random consumer stalls
        rand_en = 1'b1;
        fork
            begin
                while (rand_en) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_rand();
        end
        rand_en = 1'b0;
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check_val("final_drain", exp_q.size(), 0);
        check_val("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d errors so far, expected completion", err_cnt);
        $fatal(1, "watchdog");
    end

endmodule
